maxpool2x2_stream: RTL and testbench

- Streaming 2x2/stride-2 max-pool stage that sits directly downstream of the layer-1 `cnn` block.
- Consumes its 16-channel, 8-bit, raster-order feature-map stream (14x14 per channel) and emits a 7x7x16 pooled stream to the layer-2 input.
- All channels are processed in parallel, one beat per pixel position.
- There is no backpressure: the producer has no ready signal, so this block must accept every beat.

---
 rtl/maxpool2x2_stream.sv | 139 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a CH-channel raster feature map.
// Every beat is accepted; one pooled beat is emitted per completed 2x2 window.
module maxpool2x2_stream #(
    parameter int unsigned CH   = 16,
    parameter int unsigned DW   = 8,
    parameter int unsigned IN_W = 14,
    parameter int unsigned IN_H = 14
) (
    input  logic               axi_clk,
    input  logic               axi_rst_n,
    input  logic [CH-1:0]      i_data_valid,
    input  logic [CH*DW-1:0]   i_data,
    input  logic               i_clear,
    output logic               o_data_valid,
    output logic [CH*DW-1:0]   o_data,
    output logic               o_frame_done,
    output logic               o_err
);

    localparam int unsigned BusW  = CH * DW;
    localparam int unsigned PoolW = IN_W / 2;
    localparam int unsigned CW    = $clog2(IN_W);
    localparam int unsigned RW    = $clog2(IN_H);
    localparam int unsigned PW    = CW - 1;

    localparam logic [CW-1:0] ColLast = CW'(IN_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IN_H - 1);
    localparam logic [CW-1:0] ColOne  = CW'(1);
    localparam logic [RW-1:0] RowOne  = RW'(1);

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [BusW-1:0] hold_q, hold_d;
    logic [BusW-1:0] rowbuf_q [PoolW];
    logic            rb_we;

    logic            valid_q, valid_d;
    logic [BusW-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            beat;
    logic [PW-1:0]   pidx;
    logic [BusW-1:0] hmax;
    logic [BusW-1:0] pmax;

    assign beat = |i_data_valid;
    assign pidx = col_q[CW-1:1];

    // Horizontal max of the current pair, then vertical max against the buffered upper row.
    always_comb begin
        hmax = '0;
        pmax = '0;
        for (int k = 0; k < int'(CH); k++) begin
            hmax[k*DW +: DW] = (hold_q[k*DW +: DW] > i_data[k*DW +: DW]) ?
                               hold_q[k*DW +: DW] : i_data[k*DW +: DW];
        end
        for (int k = 0; k < int'(CH); k++) begin
            pmax[k*DW +: DW] = (rowbuf_q[pidx][k*DW +: DW] > hmax[k*DW +: DW]) ?
                               rowbuf_q[pidx][k*DW +: DW] : hmax[k*DW +: DW];
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        rb_we   = 1'b0;
        valid_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (i_clear) begin
            // Frame abort: any concurrent beat is discarded.
            col_d = '0;
            row_d = '0;
            err_d = 1'b0;
        end else if (beat) begin
            if (i_data_valid != {CH{1'b1}}) begin
                err_d = 1'b1;
            end

            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowOne;
            end else begin
                col_d = col_q + ColOne;
            end

            if (!col_q[0]) begin
                hold_d = i_data;
            end else if (!row_q[0]) begin
                rb_we = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = pmax;
                done_d  = (row_q == RowLast) && (col_q == ColLast);
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Row buffer is never cleared between frames: each entry is rewritten before it is read.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            for (int i = 0; i < int'(PoolW); i++) begin
                rowbuf_q[i] <= '0;
            end
        end else if (rb_we) begin
            rowbuf_q[pidx] <= hmax;
        end
    end

    assign o_data_valid = valid_q;
    assign o_data       = data_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Randomised and directed stimulus for maxpool2x2_stream with a queue-based scoreboard.
// Expected windows are computed as whole 2x2 maxima over a stored copy of the frame.
module tb_maxpool2x2_stream;

    localparam int CH   = 16;
    localparam int DW   = 8;
    localparam int IN_W = 14;
    localparam int IN_H = 14;
    localparam int BW   = CH * DW;
    localparam int NPIX = IN_W * IN_H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] vld;
    logic [BW-1:0] din;
    logic          clr;
    logic          o_data_valid;
    logic [BW-1:0] o_data;
    logic          o_frame_done;
    logic          o_err;

    maxpool2x2_stream #(
        .CH   (CH),
        .DW   (DW),
        .IN_W (IN_W),
        .IN_H (IN_H)
    ) dut (
        .axi_clk      (clk),
        .axi_rst_n    (rst_n),
        .i_data_valid (vld),
        .i_data       (din),
        .i_clear      (clr),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        bit            done;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    logic [BW-1:0] frame [IN_H][IN_W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: per-channel maximum over the four pixels of pooled window (i,j).
    function automatic logic [BW-1:0] win_max(input int i, input int j);
        logic [BW-1:0] res;
        logic [DW-1:0] m;
        logic [DW-1:0] s;
        res = '0;
        for (int k = 0; k < CH; k++) begin
            m = '0;
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    s = frame[2*i+dy][2*j+dx][k*DW +: DW];
                    if (s > m) m = s;
                end
            end
            res[k*DW +: DW] = m;
        end
        return res;
    endfunction

    // Monitor: pops one expectation per observed output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_frame_done && !o_data_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL done_without_valid: got o_frame_done=1 with o_data_valid=0");
            end
            if (o_frame_done) done_cnt++;
            if (o_data_valid) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got data %h, expected no output", o_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("pooled_data", o_data, e.data);
                    check("frame_done", BW'(o_frame_done), BW'(e.done));
                    check("latency_cycle", BW'(cyc), BW'(e.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vld = '0;
        clr = 1'b0;
        repeat (n) step();
    endtask

    task automatic beat(input int r, input int c, input logic [CH-1:0] v, input bit clear);
        exp_t e;
        vld = v;
        din = frame[r][c];
        clr = clear;
        if (!clear && (r % 2 == 1) && (c % 2 == 1)) begin
            e.data = win_max(r / 2, c / 2);
            e.done = (r == IN_H - 1) && (c == IN_W - 1);
            e.cyc  = cyc + 1;
            sbq.push_back(e);
        end
        step();
        vld = '0;
        clr = 1'b0;
    endtask

    // Sends raster beats [first, last) of the stored frame.
    task automatic send(input int first, input int last, input int gap_b, input int gap_r,
                        input int bad_at);
        for (int idx = first; idx < last; idx++) begin
            int r;
            int c;
            r = idx / IN_W;
            c = idx % IN_W;
            beat(r, c, (idx == bad_at) ? 16'h00FF : 16'hFFFF, 1'b0);
            if (gap_b > 0) idle(gap_b);
            if (gap_r > 0 && c == IN_W - 1) idle(gap_r);
        end
    endtask

    task automatic fill_ramp(input bit inv);
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                for (int k = 0; k < CH; k++)
                    frame[r][c][k*DW +: DW] = inv ? DW'(255 - (r*IN_W + c + k))
                                                  : DW'(r*IN_W + c + k);
    endtask

    task automatic fill_sweep();
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                frame[r][c] = '0;
        for (int i = 0; i < IN_H / 2; i++)
            for (int j = 0; j < IN_W / 2; j++)
                for (int k = 0; k < CH; k += 2) begin
                    int p;
                    p = (i * (IN_W / 2) + j + k / 2) % 4;
                    frame[2*i + p/2][2*j + p%2][k*DW +: DW] = 8'd255;
                end
    endtask

    task automatic fill_random();
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                for (int k = 0; k < CH; k++)
                    frame[r][c][k*DW +: DW] = DW'($urandom_range(0, 255));
    endtask

    initial begin
        int d0;
        vld = '0;
        din = '0;
        clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_valid", BW'(o_data_valid), BW'(0));
        check("reset_data", o_data, '0);
        check("reset_done", BW'(o_frame_done), BW'(0));
        check("reset_err", BW'(o_err), BW'(0));
        rst_n = 1'b1;
        idle(2);

        fill_ramp(1'b0);
        send(0, NPIX, 0, 0, -1);
        idle(3);

        fill_sweep();
        send(0, NPIX, 0, 0, -1);
        idle(2);

        for (int n = 0; n < 2; n++) begin
            fill_random();
            send(0, NPIX, $urandom_range(0, 1), $urandom_range(0, 4), -1);
        end
        idle(2);

        fill_ramp(1'b0);
        send(0, NPIX, 3, 30, -1);
        idle(5);
        check("err_clean_stream", BW'(o_err), BW'(0));

        // Partial valid mid-frame sets the sticky error.
        send(0, 50, 0, 0, -1);
        check("err_before_partial", BW'(o_err), BW'(0));
        send(50, 51, 0, 0, 50);
        check("err_after_partial", BW'(o_err), BW'(1));
        send(51, NPIX, 0, 0, -1);
        check("err_sticky_frame", BW'(o_err), BW'(1));
        idle(2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("err_cleared", BW'(o_err), BW'(0));

        // Clear together with a beat, then a full frame.
        send(0, 100, 0, 0, -1);
        beat(100 / IN_W, 100 % IN_W, 16'hFFFF, 1'b1);
        send(0, NPIX, 0, 0, -1);
        idle(2);

        // Clear on a beat that would otherwise produce an output.
        send(0, 43, 0, 0, -1);
        idle(1);
        beat(3, 1, 16'hFFFF, 1'b1);
        check("clear_drops_output", BW'(o_data_valid), BW'(0));
        send(0, NPIX, 0, 0, -1);
        idle(2);

        // Asynchronous reset mid-frame.
        send(0, 100, 0, 0, -1);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        check("midreset_valid", BW'(o_data_valid), BW'(0));
        check("midreset_data", o_data, '0);
        rst_n = 1'b1;
        idle(1);
        send(0, NPIX, 0, 0, -1);
        idle(2);

        // Back-to-back ramp and inverse ramp.
        d0 = done_cnt;
        fill_ramp(1'b0);
        send(0, NPIX, 0, 0, -1);
        fill_ramp(1'b1);
        send(0, NPIX, 0, 0, -1);
        idle(3);
        check("b2b_frame_done_count", BW'(done_cnt - d0), BW'(2));

        idle(5);
        check("scoreboard_drained", BW'(sbq.size()), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
